// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold-time limit.
// Registered one-hot grant plus binary index, switching without an idle bubble.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_hold_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_valid;

    logic [1:0] w_base;
    logic [3:0] w_cand;
    logic [1:0] w_try;
    logic [1:0] w_win;
    logic       w_found;
    logic       w_own_req;
    logic       w_take;

    // While granted, the search starts after the owner and excludes it.
    assign w_base    = (r_state == ST_GRANT) ? r_gnt_idx : r_last;
    assign w_cand    = req & ~((r_state == ST_GRANT) ? r_gnt : 4'b0000);
    assign w_own_req = req[r_gnt_idx];

    always_comb begin
        w_found = 1'b0;
        w_win   = w_base;
        w_try   = w_base;
        for (int k = 1; k <= 4; k++) begin
            w_try = w_base + 2'(k);
            if (!w_found && w_cand[w_try]) begin
                w_found = 1'b1;
                w_win   = w_try;
            end
        end
    end

    // A new owner is taken on release or on an expired hold, if anyone else waits.
    assign w_take = w_found &&
                    ((r_state == ST_IDLE) || !w_own_req || (r_hold_cnt == HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 2'b11;
            r_hold_cnt  <= '0;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'b00;
            r_gnt_valid <= 1'b0;
        end else if (w_take) begin
            r_state     <= ST_GRANT;
            r_last      <= w_win;
            r_hold_cnt  <= HOLD_ONE;
            r_gnt       <= 4'b0001 << w_win;
            r_gnt_idx   <= w_win;
            r_gnt_valid <= 1'b1;
        end else if (r_state == ST_GRANT) begin
            if (!w_own_req) begin
                r_state     <= ST_IDLE;
                r_hold_cnt  <= '0;
                r_gnt       <= 4'b0000;
                r_gnt_valid <= 1'b0;
            end else if (r_hold_cnt < HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + HOLD_ONE;
            end else begin
                // Sole requester at the limit keeps the grant with a fresh count.
                r_hold_cnt <= HOLD_ONE;
            end
        end
    end

    assign gnt            = r_gnt;
    assign gnt_idx        = r_gnt_idx;
    assign gnt_valid      = r_gnt_valid;
    assign o_dbg_state    = r_state;
    assign o_dbg_hold_cnt = r_hold_cnt;

endmodule
